// File: rtl/demux4_deser.sv
// demux4_deser: 1:4 time-division demultiplexer (deserializer) with
// registered outputs. Words arrive on a shared bus in slot order 0,1,2,3;
// each is distributed to its lane. A slot counter tracks the frame, SYNC
// realigns it to slot 0, ERR flags a truncated frame, and QV pulses when a
// full frame has been delivered.
//
// Optional build macro: DEMUX4_SHADOW_EN
//   defined   - slots 0..2 go to shadow registers and all four lanes update
//               together on the slot-3 edge (outputs are always frame-coherent).
//   undefined - each lane updates directly on the edge that captures its slot.
module demux4_deser #(
    parameter int WIDTH = 1
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic [WIDTH-1:0] D,
    input  logic             DV,
    input  logic             SYNC,
    output logic [WIDTH-1:0] Q0,
    output logic [WIDTH-1:0] Q1,
    output logic [WIDTH-1:0] Q2,
    output logic [WIDTH-1:0] Q3,
    output logic             QV,
    output logic [1:0]       SLOT,
    output logic             ERR
);

    logic [3:0][WIDTH-1:0] lane_q, lane_d;
    logic [1:0]            slot_q, slot_d;
    logic                  qv_q, qv_d;
    logic                  err_q, err_d;
    logic [1:0]            eff_slot;

`ifdef DEMUX4_SHADOW_EN
    logic [2:0][WIDTH-1:0] shd_q, shd_d;
`endif

    // Next-state: slot tracking, lane/shadow capture and status pulses.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        slot_d = slot_q;
        lane_d = lane_q;
        qv_d   = 1'b0;
        err_d  = 1'b0;
`ifdef DEMUX4_SHADOW_EN
        shd_d  = shd_q;
`endif
        // SYNC forces the current word to slot 0 regardless of the counter.
        eff_slot = SYNC ? 2'd0 : slot_q;

        if (DV) begin
            slot_d = eff_slot + 2'd1;
            qv_d   = (eff_slot == 2'd3);
            err_d  = SYNC && (slot_q != 2'd0);
`ifdef DEMUX4_SHADOW_EN
            case (eff_slot)
                2'd0: shd_d[0] = D;
                2'd1: shd_d[1] = D;
                2'd2: shd_d[2] = D;
                default: begin
                    lane_d[0] = shd_q[0];
                    lane_d[1] = shd_q[1];
                    lane_d[2] = shd_q[2];
                    lane_d[3] = D;
                end
            endcase
`else
            lane_d[eff_slot] = D;
`endif
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RN) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values; blocking here would create ordering races.
        if (!RN) begin
            lane_q <= '0;
            slot_q <= 2'd0;
            qv_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            lane_q <= lane_d;
            slot_q <= slot_d;
            qv_q   <= qv_d;
            err_q  <= err_d;
        end
    end

`ifdef DEMUX4_SHADOW_EN
    // Shadow registers holding slots 0..2 until the frame completes.
    always_ff @(posedge CLK or negedge RN) begin
        // NOTE: the shadows are a tiny register bank, not a RAM, so they are
        // reset explicitly; a partial frame must not leak across a reset.
        if (!RN) begin
            shd_q <= '0;
        end else begin
            shd_q <= shd_d;
        end
    end
`endif

    assign Q0   = lane_q[0];
    assign Q1   = lane_q[1];
    assign Q2   = lane_q[2];
    assign Q3   = lane_q[3];
    assign QV   = qv_q;
    assign SLOT = slot_q;
    assign ERR  = err_q;

endmodule
